uart_tx_queue: RTL

//   Byte queue feeding async_transmitter. Buffers bytes from a producer, then issues one
//   TxD_start pulse per byte using TxD_busy as flow control. Decouples bursty writers

---
 rtl/uart_tx_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Byte queue feeding async_transmitter: buffers producer writes and issues one tx_start per byte.
// Optional UART_TXQ_STATS_EN adds saturating sent_cnt / timeout_cnt outputs.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  idle,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
`ifdef UART_TXQ_STATS_EN
  output logic [15:0]           sent_cnt,
  output logic [7:0]            timeout_cnt,
`endif
  input  logic                  tx_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TW    = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [TW-1:0]         TMR_MAX  = TW'(BUSY_TIMEOUT);
  localparam logic [TW-1:0]         TMR_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} stateT;

  stateT                  state;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wrPtr;
  logic [DEPTH_LOG2-1:0]  rdPtr;
  logic [TW-1:0]          timer;
  logic                   wrAccept;
  logic                   pop;
  logic                   timeoutHit;

  assign full = (count == CNT_FULL);
  assign idle = (count == '0) && (state == IDLE);

  // Both decisions use registered count, so a pop never frees space for a same-cycle write.
  always_comb begin
    wrAccept   = wr_en && !full;
    pop        = (state == IDLE) && (count != '0) && !tx_busy;
    timeoutHit = (state == WAIT_BUSY) && !tx_busy && (timer == TMR_MAX);
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      timer    <= '0;
    end else begin
      if (wrAccept)          wrPtr    <= wrPtr + PTR_ONE;
      if (wr_en && full)     overflow <= 1'b1;
      if (pop)               rdPtr    <= rdPtr + PTR_ONE;
      if (wrAccept && !pop)  count    <= count + CNT_ONE;
      if (pop && !wrAccept)  count    <= count - CNT_ONE;

      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rdPtr];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A byte whose start is never acknowledged counts as consumed; no retry.
          if (tx_busy)         state <= WAIT_DONE;
          else if (timeoutHit) state <= IDLE;
          else                 timer <= timer + TMR_ONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if ((state == START) && (sent_cnt != '1))  sent_cnt    <= sent_cnt + 16'd1;
      if (timeoutHit && (timeout_cnt != '1))     timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule
